// File: rtl/image_pkg.sv
// Shared types and constants for the image transmit path.
// Package image_pkg: FSM state enum, pixel byte type, frame defaults.
package image_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_GAP,
        S_CSUM,
        S_DONE
    } tx_state_t;

    typedef logic [7:0] pixel_t;

    localparam pixel_t FRAME_HEADER = 8'hA5;
    localparam int     DEF_W_BITS   = 4;
    localparam int     DEF_H_BITS   = 4;

endpackage

// File: rtl/image_uart_tx_if.sv
// Pixel-store read port and UART load port of image_uart_tx.
// master = the transmitter, slave = pixel store plus UART.
interface image_uart_tx_if
    import image_pkg::*;
#(
    parameter int W_BITS = DEF_W_BITS,
    parameter int H_BITS = DEF_H_BITS
);

    logic [W_BITS-1:0] pix_x;
    logic [H_BITS-1:0] pix_y;
    logic              pix_rd;
    pixel_t            pix_data;
    pixel_t            txdata;
    logic              txclk;
    logic              txready;

    modport master (
        output pix_x, pix_y, pix_rd, txdata, txclk,
        input  pix_data, txready
    );

    modport slave (
        input  pix_x, pix_y, pix_rd, txdata, txclk,
        output pix_data, txready
    );

endinterface

// File: rtl/raster_addr_gen.sv
// Raster x/y address counter, x fastest, wrapping at the frame corner.
// clr has priority over en; last flags the bottom-right pixel.
module raster_addr_gen
    import image_pkg::*;
#(
    parameter int W_BITS = DEF_W_BITS,
    parameter int H_BITS = DEF_H_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [W_BITS-1:0] x,
    output logic [H_BITS-1:0] y,
    output logic              last
);

    logic [W_BITS-1:0] x_q, x_d;
    logic [H_BITS-1:0] y_q, y_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (&x_q) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (&x_q) & (&y_q);

endmodule

// File: rtl/image_uart_tx.sv
// Raster-scans the pixel store and streams header + pixels onto the UART.
// Define IMAGE_UART_TX_CHECKSUM_EN to append a mod-256 pixel checksum byte.
module image_uart_tx
    import image_pkg::*;
#(
    parameter int     W_BITS = DEF_W_BITS,
    parameter int     H_BITS = DEF_H_BITS,
    parameter pixel_t HEADER = FRAME_HEADER
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    image_uart_tx_if.master       bus,
    output logic                  busy,
    output logic                  done
);

    tx_state_t state_q, state_d;
    tx_state_t nxt_q, nxt_d;
    pixel_t    byte_q, byte_d;
    pixel_t    txdata_q, txdata_d;
    pixel_t    tx_val;

    logic              live;
    logic              load;
    logic              pix_rd;
    logic              adv;
    logic              zero;
    logic              last_pix;
    logic [W_BITS-1:0] x_w;
    logic [H_BITS-1:0] y_w;

    // Abort and reset suppress every strobe in the cycle they are seen.
    assign live = ~reset & ~clear;
    assign zero = clear | ((state_q == S_IDLE) & start);

    raster_addr_gen #(
        .W_BITS (W_BITS),
        .H_BITS (H_BITS)
    ) u_addr (
        .clk   (clk),
        .reset (reset),
        .clr   (zero),
        .en    (adv),
        .x     (x_w),
        .y     (y_w),
        .last  (last_pix)
    );

`ifdef IMAGE_UART_TX_CHECKSUM_EN
    pixel_t acc_q, acc_d;

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    always_comb begin
        acc_d = acc_q;
        if (zero)     acc_d = '0;
        else if (adv) acc_d = acc_q + byte_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            nxt_q    <= S_IDLE;
            byte_q   <= '0;
            txdata_q <= '0;
        end else begin
            state_q  <= state_d;
            nxt_q    <= nxt_d;
            byte_q   <= byte_d;
            txdata_q <= txdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        if (clear) begin
            state_d = S_IDLE;
            nxt_d   = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start) state_d = S_HDR;
                S_HDR: begin
                    if (bus.txready) begin
                        state_d = S_GAP;
                        nxt_d   = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_SEND;
                S_SEND: begin
                    if (bus.txready) begin
                        state_d = S_GAP;
`ifdef IMAGE_UART_TX_CHECKSUM_EN
                        nxt_d = last_pix ? S_CSUM : S_FETCH;
`else
                        nxt_d = last_pix ? S_DONE : S_FETCH;
`endif
                    end
                end
                // One idle cycle so the UART can drop txready.
                S_GAP:   state_d = nxt_q;
`ifdef IMAGE_UART_TX_CHECKSUM_EN
                S_CSUM: begin
                    if (bus.txready) begin
                        state_d = S_GAP;
                        nxt_d   = S_DONE;
                    end
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        load   = 1'b0;
        pix_rd = 1'b0;
        done   = 1'b0;
        adv    = 1'b0;
        tx_val = byte_q;
        byte_d = byte_q;
        busy   = (state_q != S_IDLE) && (state_q != S_DONE);
        unique case (state_q)
            S_HDR: begin
                load   = bus.txready & live;
                tx_val = HEADER;
            end
            S_FETCH: pix_rd = live;
            S_WAIT:  byte_d = bus.pix_data;
            S_SEND: begin
                load = bus.txready & live;
                adv  = load;
            end
`ifdef IMAGE_UART_TX_CHECKSUM_EN
            S_CSUM: begin
                load   = bus.txready & live;
                tx_val = acc_q;
            end
`endif
            S_DONE:  done = live;
            default: ;
        endcase
        txdata_d = load ? tx_val : txdata_q;
    end

    assign bus.pix_x  = x_w;
    assign bus.pix_y  = y_w;
    assign bus.pix_rd = pix_rd;
    assign bus.txclk  = load;
    assign bus.txdata = txdata_d;

endmodule

// File: tb/tb_image_uart_tx.sv
// Directed bench for image_uart_tx: a 2x2 instance and a 16x16 instance.
// Expected bytes are hand-computed from the pixel models below.
module tb_image_uart_tx;
    import image_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s1 = 1'b0, c1 = 1'b0, s4 = 1'b0, c4 = 1'b0;
    logic busy1, done1, busy4, done4;

    image_uart_tx_if #(.W_BITS(1), .H_BITS(1)) if1 ();
    image_uart_tx_if #(.W_BITS(4), .H_BITS(4)) if4 ();

    image_uart_tx #(.W_BITS(1), .H_BITS(1), .HEADER(8'hA5)) d1 (
        .clk(clk), .reset(reset), .start(s1), .clear(c1),
        .bus(if1), .busy(busy1), .done(done1)
    );

    image_uart_tx #(.W_BITS(4), .H_BITS(4), .HEADER(8'hA5)) d4 (
        .clk(clk), .reset(reset), .start(s4), .clear(c4),
        .bus(if4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int bp1 = 0;
    int w1 = 0;

    // UART models: txready falls after each load, returns after bp1 cycles.
    always @(posedge clk) begin
        if (reset) begin
            if1.txready <= 1'b1;
            w1 <= 0;
        end else if (s1 || if1.txclk) begin
            if1.txready <= 1'b0;
            w1 <= bp1;
        end else if (w1 != 0) begin
            w1 <= w1 - 1;
        end else begin
            if1.txready <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if4.txready <= reset ? 1'b1 : !(if4.txclk || s4);
    end

    always @(posedge clk) begin
        if (if1.pix_rd)
            if1.pix_data <= 8'(8'h40 + 8'h10 * 8'(if1.pix_y) + 8'(if1.pix_x));
        if (if4.pix_rd)
            if4.pix_data <= {if4.pix_y, if4.pix_x};
    end

    logic [7:0] q1[$];
    logic [7:0] q4[$];
    logic [7:0] exp1[$];
    logic [7:0] last1 = 8'h00;
    logic       prev1 = 1'b0;
    int b2b1 = 0, stab1 = 0, dn1 = 0, dn4 = 0;

    always @(negedge clk) begin
        if (if1.txclk) begin
            q1.push_back(if1.txdata);
            if (prev1) b2b1++;
            last1 = if1.txdata;
        end else if (!reset && if1.txdata !== last1) begin
            stab1++;
        end
        prev1 = if1.txclk;
        if (done1) dn1++;
        if (if4.txclk) q4.push_back(if4.txdata);
        if (done4) dn4++;
    end

    task automatic pulse1();
        @(negedge clk) s1 = 1'b1;
        @(negedge clk) s1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s1 = 1'b1;
        s4 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (if1.txclk !== 1'b0 || if1.pix_rd !== 1'b0)
            $display("FAIL reset_strobes txclk=%b pix_rd=%b want 0 0",
                     if1.txclk, if1.pix_rd);
        if (if1.txclk !== 1'b0 || if1.pix_rd !== 1'b0) errors++;
        checks++;
        if (if1.txdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_txdata got %h want 00", if1.txdata);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done got %b%b want 00", busy1, done1);
        end
        checks++;
        if ({if1.pix_x, if1.pix_y} !== 2'b00) begin
            errors++;
            $display("FAIL reset_xy got %b%b want 00", if1.pix_x, if1.pix_y);
        end
        reset = 1'b0;
        s1 = 1'b0;
        s4 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored busy1=%b busy4=%b want 0 0",
                     busy1, busy4);
        end
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL reset_no_tx got %0d/%0d bytes want 0",
                     q1.size(), q4.size());
        end
    endtask

    task automatic test_frame(input int bp, input string tag);
        int base;
        bp1 = bp;
        q1.delete();
        b2b1 = 0;
        stab1 = 0;
        base = dn1;
        pulse1();
        for (int i = 0; i < 400 && dn1 == base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (dn1 != base + 1) begin
            errors++;
            $display("FAIL %s_done got %0d pulses want 1", tag, dn1 - base);
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after got %b want 0", tag, busy1);
        end
        checks++;
        if (q1.size() != exp1.size()) begin
            errors++;
            $display("FAIL %s_len got %0d want %0d", tag, q1.size(), exp1.size());
        end
        for (int i = 0; i < exp1.size(); i++) begin
            logic [7:0] got;
            got = (i < q1.size()) ? q1[i] : 8'hxx;
            checks++;
            if (got !== exp1[i]) begin
                errors++;
                $display("FAIL %s_byte%0d got %h want %h", tag, i, got, exp1[i]);
            end
        end
        checks++;
        if (b2b1 != 0 || stab1 != 0) begin
            errors++;
            $display("FAIL %s_txclk_spacing b2b=%0d unstable=%0d want 0 0",
                     tag, b2b1, stab1);
        end
    endtask

    task automatic test_abort();
        int base, k;
        bp1 = 0;
        q1.delete();
        base = dn1;
        pulse1();
        k = 0;
        while (q1.size() < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (q1.size() != 3) begin
            errors++;
            $display("FAIL abort_reach got %0d bytes want 3", q1.size());
        end
        @(negedge clk) c1 = 1'b1;
        @(negedge clk) c1 = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (q1.size() != 3) begin
            errors++;
            $display("FAIL abort_no_tx got %0d bytes want 3", q1.size());
        end
        checks++;
        if (dn1 != base || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle done=%0d busy=%b want 0 0", dn1 - base, busy1);
        end
        checks++;
        if ({if1.pix_x, if1.pix_y} !== 2'b00) begin
            errors++;
            $display("FAIL abort_xy got %b%b want 00", if1.pix_x, if1.pix_y);
        end
        test_frame(0, "restart");
    endtask

    task automatic test_default_size();
        int base, n;
        q4.delete();
        base = dn4;
        @(negedge clk) s4 = 1'b1;
        @(negedge clk) s4 = 1'b0;
        for (int i = 0; i < 3000 && dn4 == base; i++) @(negedge clk);
        checks++;
        if (dn4 != base + 1) begin
            errors++;
            $display("FAIL big_done got %0d pulses want 1", dn4 - base);
        end
`ifdef IMAGE_UART_TX_CHECKSUM_EN
        n = 258;
`else
        n = 257;
`endif
        checks++;
        if (q4.size() != n) begin
            errors++;
            $display("FAIL big_len got %0d want %0d", q4.size(), n);
        end
        if (q4.size() >= 257) begin
            checks++;
            if (q4[0] !== 8'hA5) begin
                errors++;
                $display("FAIL big_header got %h want a5", q4[0]);
            end
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (q4[i+1] !== 8'(i)) begin
                    errors++;
                    $display("FAIL big_pix%0d got %h want %h", i, q4[i+1], 8'(i));
                end
            end
            checks++;
            if (q4[256] !== 8'hFF) begin
                errors++;
                $display("FAIL big_last got %h want ff", q4[256]);
            end
`ifdef IMAGE_UART_TX_CHECKSUM_EN
            if (q4.size() == 258) begin
                checks++;
                if (q4[257] !== 8'h80) begin
                    errors++;
                    $display("FAIL big_csum got %h want 80", q4[257]);
                end
            end
`endif
        end
    endtask

    task automatic test_start_while_busy();
        int base, k;
        bp1 = 0;
        q1.delete();
        base = dn1;
        pulse1();
        k = 0;
        while (q1.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        pulse1();
        for (int i = 0; i < 400 && dn1 == base; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        checks++;
        if (dn1 != base + 1) begin
            errors++;
            $display("FAIL busy_start_done got %0d pulses want 1", dn1 - base);
        end
        checks++;
        if (q1.size() != exp1.size()) begin
            errors++;
            $display("FAIL busy_start_len got %0d want %0d", q1.size(), exp1.size());
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle got %b want 0", busy1);
        end
    endtask

    initial begin
        exp1 = '{8'hA5, 8'h40, 8'h41, 8'h50, 8'h51};
`ifdef IMAGE_UART_TX_CHECKSUM_EN
        exp1.push_back(8'h22);
`endif
        test_reset();
        test_frame(0, "basic");
        test_frame(5, "backpressure");
        test_abort();
        test_default_size();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
